// File: rtl/line_buf_ring_ctrl.sv
// N-line video delay / vertical tap generator: NLINE+1 line RAMs in a ring,
// one written per line while the other NLINE feed vertically aligned taps.
module line_buf_ring_ctrl #(
   parameter int unsigned HTOT  = 15,
   parameter int unsigned HACT  = 10,
   parameter int unsigned NCH   = 3,
   parameter int unsigned DW    = 10,
   parameter int unsigned NLINE = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_vsync,
   input  logic                      i_hsync,
   input  logic                      i_de,
   input  logic [NCH*DW-1:0]         i_data,
   output logic                      o_vsync,
   output logic                      o_hsync,
   output logic                      o_de,
   output logic [NLINE*NCH*DW-1:0]   o_tap_data,
   output logic [NLINE-1:0]          o_tap_vld,
   output logic [NCH*DW-1:0]         o_data
);

   localparam int unsigned PW   = NCH * DW;
   localparam int unsigned D    = NLINE * HTOT + 1;
   localparam int unsigned NBUF = NLINE + 1;
   localparam int unsigned CW   = $clog2(HACT + 1);
   localparam int unsigned AW   = (HACT > 1) ? $clog2(HACT) : 1;
   localparam int unsigned IW   = $clog2(NBUF);
   localparam int unsigned LW   = $clog2(NLINE + 1);

   logic                         hsync_q, hsync_d;
   logic                         hsync_fall;
   logic [CW-1:0]                pixel_cnt_q, pixel_cnt_d;
   logic [IW-1:0]                wr_idx_q, wr_idx_d;
   logic [LW-1:0]                lines_seen_q, lines_seen_d;
   logic [D-1:0][2:0]            sync_q, sync_d;
   logic [NLINE-1:0][PW-1:0]     tap_q, tap_d;
   logic [NLINE-1:0]             vld_q, vld_d;
   logic                         in_range;
   logic                         wr_en;
   logic [AW-1:0]                addr;

   logic [PW-1:0]                mem [NBUF][HACT];

   // Slot holding the line entered k+1 lines ago: (wr_idx-1-k) mod NBUF.
   function automatic logic [IW-1:0] rd_slot(input logic [IW-1:0] w, input int unsigned k);
      int unsigned s;
      s = 32'(w) + NLINE - k;
      if (s >= NBUF) s = s - NBUF;
      return IW'(s);
   endfunction

   always_comb begin
      hsync_d    = i_hsync;
      hsync_fall = hsync_q & ~i_hsync;
      in_range   = (pixel_cnt_q < CW'(HACT));
      wr_en      = i_de & ~i_vsync & in_range;
      addr       = AW'(pixel_cnt_q);

      pixel_cnt_d = pixel_cnt_q;
      if (i_vsync || hsync_fall) begin
         pixel_cnt_d = '0;
      end else if (i_de && in_range) begin
         pixel_cnt_d = pixel_cnt_q + 1'b1;
      end

      wr_idx_d     = wr_idx_q;
      lines_seen_d = lines_seen_q;
      if (i_vsync) begin
         wr_idx_d     = '0;
         lines_seen_d = '0;
      end else if (hsync_fall) begin
         wr_idx_d     = (wr_idx_q == IW'(NLINE)) ? '0 : wr_idx_q + 1'b1;
         lines_seen_d = (lines_seen_q == LW'(NLINE)) ? lines_seen_q : lines_seen_q + 1'b1;
      end
   end

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {i_vsync, i_hsync, i_de};
      for (int unsigned i = 1; i < D; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Combinational RAM read captured in tap_q forms the 1-cycle synchronous read.
   always_comb begin
      vld_d = '0;
      tap_d = '0;
      for (int unsigned k = 0; k < NLINE; k++) begin
         vld_d[k] = (32'(lines_seen_q) > k);
         if (i_de && vld_d[k] && in_range) begin
            tap_d[k] = mem[rd_slot(wr_idx_q, k)][addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx_q][addr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q      <= 1'b0;
         pixel_cnt_q  <= '0;
         wr_idx_q     <= '0;
         lines_seen_q <= '0;
         sync_q       <= '0;
         tap_q        <= '0;
         vld_q        <= '0;
      end else begin
         hsync_q      <= hsync_d;
         pixel_cnt_q  <= pixel_cnt_d;
         wr_idx_q     <= wr_idx_d;
         lines_seen_q <= lines_seen_d;
         sync_q       <= sync_d;
         tap_q        <= tap_d;
         vld_q        <= vld_d;
      end
   end

   always_comb begin
      o_vsync    = sync_q[D-1][2];
      o_hsync    = sync_q[D-1][1];
      o_de       = sync_q[D-1][0];
      o_tap_data = tap_q;
      o_tap_vld  = vld_q;
      o_data     = tap_q[NLINE-1];
   end

endmodule

// File: tb/tb_line_buf_ring_ctrl.sv
// Scoreboard bench for line_buf_ring_ctrl: a default instance (NLINE=2) and a
// NLINE=4, NCH=1, DW=8 instance share the same video timing.
module tb_line_buf_ring_ctrl;

   localparam int unsigned HTOT = 15;
   localparam int unsigned HACT = 10;
   localparam int unsigned NL0  = 2;
   localparam int unsigned NL1  = 4;
   localparam int unsigned D0   = 31;
   localparam int unsigned D1   = 61;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
   logic [29:0] din0 = '0;
   logic [7:0]  din1 = '0;

   logic        o_vsync0, o_hsync0, o_de0, o_vsync1, o_hsync1, o_de1;
   logic [59:0] o_tap_data0;
   logic [1:0]  o_tap_vld0;
   logic [29:0] o_data0;
   logic [31:0] o_tap_data1;
   logic [3:0]  o_tap_vld1;
   logic [7:0]  o_data1;

   line_buf_ring_ctrl #(.HTOT(HTOT), .HACT(HACT), .NCH(3), .DW(10), .NLINE(NL0)) dut0 (
      .clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_data(din0),
      .o_vsync(o_vsync0), .o_hsync(o_hsync0), .o_de(o_de0),
      .o_tap_data(o_tap_data0), .o_tap_vld(o_tap_vld0), .o_data(o_data0));

   line_buf_ring_ctrl #(.HTOT(HTOT), .HACT(HACT), .NCH(1), .DW(8), .NLINE(NL1)) dut1 (
      .clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_data(din1),
      .o_vsync(o_vsync1), .o_hsync(o_hsync1), .o_de(o_de1),
      .o_tap_data(o_tap_data1), .o_tap_vld(o_tap_vld1), .o_data(o_data1));

   always #5 clk = ~clk;

   typedef struct {
      int unsigned      due;
      logic [3:0]       vld;
      logic [3:0][29:0] tap;
      logic             dc;
   } tap_t;

   typedef struct {
      int unsigned due;
      logic [2:0]  sync;
      logic        has_pix;
      logic [29:0] pix;
   } dly_t;

   tap_t tq0[$], tq1[$];
   dly_t dq0[$], dq1[$];

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   bit          run = 0;
   int unsigned gl = 0;

   // Reference state: lines indexed by position in the frame, not by ring slot.
   bit          m_hs_prev = 0;
   int unsigned m_cnt = 0;
   int unsigned m_ln = 0;
   logic [29:0] m0 [64][HACT];
   logic [7:0]  m1 [64][HACT];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      tap_t t0, t1;
      dly_t d;
      bit   fall;
      if (rst) begin
         while (dq0.size() > 0 && dq0[$].due > cyc) void'(dq0.pop_back());
         while (dq1.size() > 0 && dq1[$].due > cyc) void'(dq1.pop_back());
         m_hs_prev = 0;
         m_cnt     = 0;
         m_ln      = 0;
      end else begin
         fall = m_hs_prev && !hs;
         t0 = '{due: cyc + 1, vld: '0, tap: '0, dc: (de && m_cnt >= HACT)};
         t1 = t0;
         for (int k = 0; k < 4; k++) begin
            if (k < NL0 && m_ln > k) begin
               t0.vld[k] = 1'b1;
               if (de && m_cnt < HACT) t0.tap[k] = m0[(m_ln - 1 - k) % 64][m_cnt];
            end
            if (k < NL1 && m_ln > k) begin
               t1.vld[k] = 1'b1;
               if (de && m_cnt < HACT) t1.tap[k] = 30'(m1[(m_ln - 1 - k) % 64][m_cnt]);
            end
         end
         tq0.push_back(t0);
         tq1.push_back(t1);
         if (vs) begin
            for (int i = 0; i < dq0.size(); i++) begin
               d = dq0[i]; d.has_pix = 1'b0; dq0[i] = d;
            end
            for (int i = 0; i < dq1.size(); i++) begin
               d = dq1[i]; d.has_pix = 1'b0; dq1[i] = d;
            end
         end
         d = '{due: cyc + D0, sync: {vs, hs, de}, has_pix: (de && !vs && m_cnt < HACT), pix: din0};
         dq0.push_back(d);
         d.due = cyc + D1;
         d.pix = 30'(din1);
         dq1.push_back(d);
         if (de && !vs && m_cnt < HACT) begin
            m0[m_ln % 64][m_cnt] = din0;
            m1[m_ln % 64][m_cnt] = din1;
         end
         if (vs) begin
            m_cnt = 0;
            m_ln  = 0;
         end else if (fall) begin
            m_cnt = 0;
            m_ln++;
         end else if (de && m_cnt < HACT) begin
            m_cnt++;
         end
         m_hs_prev = hs;
      end
   endtask

   task automatic cycle(input bit r, input bit v, input bit h, input bit e,
                        input logic [29:0] p0, input logic [7:0] p1);
      @(posedge clk);
      #1;
      rst = r; vs = v; hs = h; de = e; din0 = p0; din1 = p1;
      cyc++;
      run = 1;
      model_step();
   endtask

   // One HTOT line: hsync at p0..p1, back porch p2, active from p3 for nde clocks.
   task automatic drive_line(input bit vline, input bit vfirst, input int unsigned nde,
                             input bit rline, input int unsigned j);
      bit e, v, r;
      int unsigned col;
      for (int unsigned p = 0; p < HTOT; p++) begin
         e   = !vline && p >= 3 && p < 3 + nde;
         v   = vline || (vfirst && p <= 2);
         r   = rline && p <= 2;
         col = (p >= 3) ? p - 3 : 0;
         cycle(r, v, p < 2, e, {10'(gl), 10'(j), 10'(col)}, {4'(gl), 4'(col)});
      end
      gl++;
   endtask

   task automatic frame(input int unsigned nlines, input int olong, input int rline);
      drive_line(1, 0, 0, 0, 0);
      for (int unsigned j = 0; j < nlines; j++) begin
         drive_line(0, j == 0, (int'(j) == olong) ? 12 : HACT, int'(j) == rline, j);
      end
   endtask

   always @(negedge clk) begin
      tap_t t;
      dly_t d;
      if (run) begin
         t = '{due: 0, vld: '0, tap: '0, dc: 1'b0};
         if (tq0.size() > 0 && tq0[0].due == cyc) t = tq0.pop_front();
         check_eq("vld0", 64'(o_tap_vld0), 64'(t.vld[1:0]));
         if (!t.dc) begin
            for (int k = 0; k < NL0; k++)
               check_eq($sformatf("tap0_%0d", k), 64'(o_tap_data0[k*30 +: 30]), 64'(t.tap[k]));
            check_eq("data0", 64'(o_data0), 64'(t.tap[NL0-1]));
         end
         t = '{due: 0, vld: '0, tap: '0, dc: 1'b0};
         if (tq1.size() > 0 && tq1[0].due == cyc) t = tq1.pop_front();
         check_eq("vld1", 64'(o_tap_vld1), 64'(t.vld));
         if (!t.dc) begin
            for (int k = 0; k < NL1; k++)
               check_eq($sformatf("tap1_%0d", k), 64'(o_tap_data1[k*8 +: 8]), 64'(t.tap[k][7:0]));
            check_eq("data1", 64'(o_data1), 64'(t.tap[NL1-1][7:0]));
         end
         d = '{due: 0, sync: '0, has_pix: 1'b0, pix: '0};
         if (dq0.size() > 0 && dq0[0].due == cyc) d = dq0.pop_front();
         check_eq("sync0", 64'({o_vsync0, o_hsync0, o_de0}), 64'(d.sync));
         if (d.has_pix) check_eq("pixdly0", 64'(o_data0), 64'(d.pix));
         d = '{due: 0, sync: '0, has_pix: 1'b0, pix: '0};
         if (dq1.size() > 0 && dq1[0].due == cyc) d = dq1.pop_front();
         check_eq("sync1", 64'({o_vsync1, o_hsync1, o_de1}), 64'(d.sync));
         if (d.has_pix) check_eq("pixdly1", 64'(o_data1), 64'(d.pix[7:0]));
      end
   end

   initial begin
      repeat (3) cycle(1, 0, 0, 0, '0, '0);
      frame(4, -1, -1);
      frame(6, -1, -1);
      frame(4, 1, -1);
      frame(6, -1, 2);
      drive_line(1, 0, 0, 0, 0);
      for (int unsigned i = 0; i < 5; i++) drive_line(0, 0, 0, 0, i);
      cycle(0, 0, 0, 0, '0, '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
